serial2parallel: RTL and testbench

Deserializer that sits directly downstream of `parallel2serial` and consumes its framed bit stream (`serial_start` / `serial_out` / `serial_end`). It reassembles each frame into a `WIDTH`-bit word, presents it with a one-cycle valid pulse and flags malformed frames. Together the pair forms the loopback path used to check the serializer end to end.

---
 rtl/serdes_pkg.sv | 16 +
 rtl/s2p_shifter.sv | 62 ++++++
 rtl/serial2parallel.sv | 105 ++++++++++
 tb/tb_serial2parallel.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Definitions shared by the parallel2serial / serial2parallel pair.
package serdes_pkg;

    localparam int SERDES_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } s2p_state_t;

    // Position in the parallel word of the idx-th serial bit of a frame.
    function automatic int bit_order(input bit msb_first, input int idx, input int width);
        return msb_first ? (width - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/s2p_shifter.sv
// Shift register and bit counter of the deserializer.
// Control priority is clear > load > shift.
module s2p_shifter
    import serdes_pkg::*;
#(
    parameter int WIDTH     = SERDES_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic                     shift_i,
    input  logic                     clear_i,
    input  logic                     bit_i,
    output logic [WIDTH-1:0]         word_next_o,
    output logic [$clog2(WIDTH)-1:0] cnt_o
);

    localparam int CW = $clog2(WIDTH);
    // Every incoming bit enters where the last bit of a frame finally sits.
    localparam int INS_POS = bit_order(MSB_FIRST, WIDTH - 1, WIDTH);

    logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {sreg_q[WIDTH-2:0], bit_i};
        end else begin
            shifted = {bit_i, sreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            sreg_d = WIDTH'(bit_i) << INS_POS;
            cnt_d  = CW'(1);
        end else if (shift_i) begin
            sreg_d = shifted;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_next_o = shifted;
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/serial2parallel.sv
// Deserializer for the framed stream of parallel2serial: rebuilds WIDTH-bit
// words, pulses out_valid on good frames and frame_err on discarded ones.
module serial2parallel
    import serdes_pkg::*;
#(
    parameter int WIDTH     = SERDES_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_start,
    input  logic             serial_in,
    input  logic             serial_end,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    s2p_state_t       state_q, state_d;
    logic [WIDTH-1:0] parallel_out_q, parallel_out_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             load, shift, clear;
    logic [WIDTH-1:0] word_next;
    logic [CW-1:0]    cnt;
    logic             lastBit;

    s2p_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .shift_i     (shift),
        .clear_i     (clear),
        .bit_i       (serial_in),
        .word_next_o (word_next),
        .cnt_o       (cnt)
    );

    assign lastBit = (cnt == CW'(WIDTH - 1));

    // A start always wins in SHIFT, so a start+end there is treated as a restart.
    always_comb begin
        state_d        = state_q;
        parallel_out_d = parallel_out_q;
        out_valid_d    = 1'b0;
        frame_err_d    = 1'b0;
        load           = 1'b0;
        shift          = 1'b0;
        clear          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (serial_start && serial_end) begin
                    frame_err_d = 1'b1;
                end else if (serial_start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (serial_start) begin
                    frame_err_d = 1'b1;
                    load        = 1'b1;
                end else if (serial_end && lastBit) begin
                    parallel_out_d = word_next;
                    out_valid_d    = 1'b1;
                    clear          = 1'b1;
                    state_d        = IDLE;
                end else if (serial_end || lastBit) begin
                    frame_err_d = 1'b1;
                    clear       = 1'b1;
                    state_d     = IDLE;
                end else begin
                    shift = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            parallel_out_q <= '0;
            out_valid_q    <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            parallel_out_q <= parallel_out_d;
            out_valid_q    <= out_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign parallel_out = parallel_out_q;
    assign out_valid    = out_valid_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q == SHIFT);

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel: an MSB-first and an LSB-first instance
// share one stimulus stream; each scenario task checks its own expectations.
module tb_serial2parallel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial_start = 1'b0;
    logic       serial_in = 1'b0;
    logic       serial_end = 1'b0;
    logic [7:0] pout, poutLsb;
    logic       ov, ovLsb, fe, feLsb, busy, busyLsb;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    serial2parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_start (serial_start),
        .serial_in    (serial_in),
        .serial_end   (serial_end),
        .parallel_out (pout),
        .out_valid    (ov),
        .frame_err    (fe),
        .busy         (busy)
    );

    serial2parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_start (serial_start),
        .serial_in    (serial_in),
        .serial_end   (serial_end),
        .parallel_out (poutLsb),
        .out_valid    (ovLsb),
        .frame_err    (feLsb),
        .busy         (busyLsb)
    );

    // Inputs change on the falling edge; checks right after a drive see the
    // outputs registered on the preceding rising edge.
    task automatic drive(input logic s, input logic d, input logic e);
        @(negedge clk);
        serial_start = s;
        serial_in    = d;
        serial_end   = e;
    endtask

    task automatic sendBits(input logic [7:0] w, input int n, input bit withEnd, input bit lsbFirst);
        for (int i = 0; i < n; i++) begin
            drive(i == 0, lsbFirst ? w[i] : w[7-i], withEnd && (i == n - 1));
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (pout !== 8'h00) begin bad++; $display("[TB] FAIL reset pout got=%h exp=00", pout); end
        total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL reset ov got=%b exp=0", ov); end
        total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL reset fe got=%b exp=0", fe); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy got=%b exp=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] w;
        w = 8'hD3;
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, w[7-i], i == 7);
            if (i > 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single busy bit%0d got=%b exp=1", i, busy); end
                total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL single early ov bit%0d got=%b exp=0", i, ov); end
            end
        end
        drive(0, 0, 0);
        total++; if (ov !== 1'b1) begin bad++; $display("[TB] FAIL single ov got=%b exp=1", ov); end
        total++; if (pout !== 8'hD3) begin bad++; $display("[TB] FAIL single pout got=%h exp=d3", pout); end
        total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL single fe got=%b exp=0", fe); end
        drive(0, 0, 0);
        total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL single ov width got=%b exp=0", ov); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single busy after got=%b exp=0", busy); end
        total++; if (pout !== 8'hD3) begin bad++; $display("[TB] FAIL single hold got=%h exp=d3", pout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        for (int i = 0; i <= 16; i++) begin
            w = (i < 8) ? 8'hD3 : 8'h5A;
            if (i < 16) drive((i % 8) == 0, w[7 - (i % 8)], (i % 8) == 7);
            else        drive(0, 0, 0);
            if (i == 8) begin
                total++; if (ov !== 1'b1) begin bad++; $display("[TB] FAIL b2b ov1 got=%b exp=1", ov); end
                total++; if (pout !== 8'hD3) begin bad++; $display("[TB] FAIL b2b word1 got=%h exp=d3", pout); end
            end else if (i == 16) begin
                total++; if (ov !== 1'b1) begin bad++; $display("[TB] FAIL b2b ov2 got=%b exp=1", ov); end
                total++; if (pout !== 8'h5A) begin bad++; $display("[TB] FAIL b2b word2 got=%h exp=5a", pout); end
            end else if (i > 0) begin
                total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL b2b stray ov at%0d got=%b exp=0", i, ov); end
            end
            if (i > 0) begin
                total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL b2b fe at%0d got=%b exp=0", i, fe); end
            end
        end
    endtask

    task automatic test_early_end();
        sendBits(8'hB7, 4, 1'b1, 1'b0);
        drive(0, 0, 0);
        total++; if (fe !== 1'b1) begin bad++; $display("[TB] FAIL early fe got=%b exp=1", fe); end
        total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL early ov got=%b exp=0", ov); end
        total++; if (pout !== 8'h5A) begin bad++; $display("[TB] FAIL early hold got=%h exp=5a", pout); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL early busy got=%b exp=0", busy); end
        drive(0, 0, 0);
        total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL early fe width got=%b exp=0", fe); end
    endtask

    task automatic test_restart_missing();
        logic [7:0] w;
        w = 8'h3C;
        sendBits(8'hE0, 3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, w[7-i], i == 7);
            if (i == 1) begin
                total++; if (fe !== 1'b1) begin bad++; $display("[TB] FAIL restart fe got=%b exp=1", fe); end
                total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL restart busy got=%b exp=1", busy); end
            end else if (i > 1) begin
                total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL restart fe at%0d got=%b exp=0", i, fe); end
            end
        end
        drive(0, 0, 0);
        total++; if (ov !== 1'b1) begin bad++; $display("[TB] FAIL restart ov got=%b exp=1", ov); end
        total++; if (pout !== 8'h3C) begin bad++; $display("[TB] FAIL restart word got=%h exp=3c", pout); end
        total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL restart fe final got=%b exp=0", fe); end

        sendBits(8'hFF, 8, 1'b0, 1'b0);
        drive(0, 0, 0);
        total++; if (fe !== 1'b1) begin bad++; $display("[TB] FAIL missing fe got=%b exp=1", fe); end
        total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL missing ov got=%b exp=0", ov); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL missing busy got=%b exp=0", busy); end
        total++; if (pout !== 8'h3C) begin bad++; $display("[TB] FAIL missing hold got=%h exp=3c", pout); end

        drive(0, 1, 1);
        drive(0, 0, 0);
        total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL stray end fe got=%b exp=0", fe); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL stray end busy got=%b exp=0", busy); end

        drive(1, 1, 1);
        drive(0, 0, 0);
        total++; if (fe !== 1'b1) begin bad++; $display("[TB] FAIL start+end fe got=%b exp=1", fe); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL start+end busy got=%b exp=0", busy); end
        total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL start+end ov got=%b exp=0", ov); end
    endtask

    task automatic test_reset_mid();
        sendBits(8'h99, 5, 1'b0, 1'b0);
        @(negedge clk);
        serial_start = 1'b0;
        serial_in    = 1'b1;
        serial_end   = 1'b0;
        rst_n        = 1'b0;
        #1;
        total++; if (pout !== 8'h00) begin bad++; $display("[TB] FAIL rstmid pout got=%h exp=00", pout); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid busy got=%b exp=0", busy); end
        total++; if (ov !== 1'b0) begin bad++; $display("[TB] FAIL rstmid ov got=%b exp=0", ov); end
        total++; if (fe !== 1'b0) begin bad++; $display("[TB] FAIL rstmid fe got=%b exp=0", fe); end
        drive(0, 0, 0);
        total++; if (ov !== 1'b0 || fe !== 1'b0) begin bad++; $display("[TB] FAIL rstmid pulse got=%b%b exp=00", ov, fe); end
        rst_n = 1'b1;
        sendBits(8'hA5, 8, 1'b1, 1'b0);
        drive(0, 0, 0);
        total++; if (ov !== 1'b1) begin bad++; $display("[TB] FAIL rstmid after ov got=%b exp=1", ov); end
        total++; if (pout !== 8'hA5) begin bad++; $display("[TB] FAIL rstmid after word got=%h exp=a5", pout); end
    endtask

    task automatic test_lsb_first();
        sendBits(8'hD3, 8, 1'b1, 1'b1);
        drive(0, 0, 0);
        total++; if (ovLsb !== 1'b1) begin bad++; $display("[TB] FAIL lsb ov got=%b exp=1", ovLsb); end
        total++; if (poutLsb !== 8'hD3) begin bad++; $display("[TB] FAIL lsb word got=%h exp=d3", poutLsb); end
        total++; if (feLsb !== 1'b0) begin bad++; $display("[TB] FAIL lsb fe got=%b exp=0", feLsb); end
        total++; if (busyLsb !== 1'b0) begin bad++; $display("[TB] FAIL lsb busy got=%b exp=0", busyLsb); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_early_end();
        test_restart_missing();
        test_reset_mid();
        test_lsb_first();
        drive(0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
